// File: rtl/sa_axi_pkg.sv
// sa_axi_pkg: burst types, response codes and FSM state types shared by the AXI4 burst slave
package sa_axi_pkg;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
endpackage

// File: rtl/sa_axi_addr_gen.sv
// sa_axi_addr_gen: next beat address for FIXED/INCR/WRAP bursts plus illegal-burst flag
// Ports: addr/len/burst in (current beat address, AxLEN, AxBURST); next_addr, illegal out.
module sa_axi_addr_gen
  import sa_axi_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr,
  output logic          illegal
);
  localparam int SH = $clog2(DW / 8);
  logic [AW-1:0] incr;
  logic [AW-1:0] mask;
  // Illegal bursts are walked as INCR so the beat count still drains normally.
  always_comb begin
    illegal   = burst == RSVD || (burst == WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    incr      = addr + AW'(DW / 8);
    mask      = (AW'(len) << SH) | AW'(DW / 8 - 1);
    next_addr = (illegal || burst == INCR) ? incr : burst == FIXED ? addr : (addr & ~mask) | (incr & mask);
  end
endmodule

// File: rtl/sa_axi4_burst_slave.sv
// sa_axi4_burst_slave: AXI4 burst slave with independent write/read FSMs over one simple-dual-port memory
// Ports: S_AXI_ACLK/S_AXI_ARESETN, AXI4 AW/W/B write channels and AR/R read channels (no AxSIZE).
module sa_axi4_burst_slave
  import sa_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH          = 1024,
  parameter int C_S_AXI_ADDR_WIDTH = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IDW = C_S_AXI_ID_WIDTH;
  localparam int SH = $clog2(DW / 8);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] ALIGN = ~AW'(DW / 8 - 1);
  logic [DW-1:0] mem [MEM_DEPTH];
  // Held low through reset so both address channels stay closed until the first edge after release.
  logic up;
  w_state_e w_state, w_state_nx;
  r_state_e r_state, r_state_nx;
  logic [IDW-1:0] w_id, r_id;
  logic [AW-1:0] w_addr, w_next, r_addr, r_next;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic [1:0] w_burst, r_burst, b_resp, r_resp;
  logic [DW-1:0] r_data;
  logic w_err, w_ill, r_ill, w_oor, r_oor, beat_err;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  sa_axi_addr_gen #(.AW(AW), .DW(DW)) u_wgen (
    .addr(w_addr), .len(w_len), .burst(w_burst), .next_addr(w_next), .illegal(w_ill)
  );
  sa_axi_addr_gen #(.AW(AW), .DW(DW)) u_rgen (
    .addr(r_addr), .len(r_len), .burst(r_burst), .next_addr(r_next), .illegal(r_ill)
  );
  always_comb begin
    S_AXI_AWREADY = up && w_state == W_IDLE;
    S_AXI_WREADY  = w_state == W_DATA;
    S_AXI_BVALID  = w_state == W_RESP;
    S_AXI_ARREADY = up && r_state == R_IDLE;
    S_AXI_RVALID  = r_state == R_DATA;
    S_AXI_RLAST   = r_state == R_DATA && r_cnt == 8'd0;
    S_AXI_BID     = w_id;
    S_AXI_BRESP   = b_resp;
    S_AXI_RID     = r_id;
    S_AXI_RDATA   = r_data;
    S_AXI_RRESP   = r_resp;
    aw_hs = S_AXI_AWREADY && S_AXI_AWVALID;
    w_hs  = S_AXI_WREADY && S_AXI_WVALID;
    b_hs  = S_AXI_BVALID && S_AXI_BREADY;
    ar_hs = S_AXI_ARREADY && S_AXI_ARVALID;
    r_hs  = S_AXI_RVALID && S_AXI_RREADY;
    w_oor = |(w_addr >> (SH + IW));
    r_oor = |(r_addr >> (SH + IW));
    // The burst ends on the counted beat; a WLAST that disagrees only poisons the response.
    beat_err = w_ill || w_oor || (S_AXI_WLAST != (w_cnt == 8'd0));
    w_state_nx = aw_hs ? W_DATA : (w_hs && w_cnt == 8'd0) ? W_RESP : b_hs ? W_IDLE : w_state;
    r_state_nx = ar_hs ? R_FETCH : r_state == R_FETCH ? R_DATA : r_hs ? (r_cnt == 8'd0 ? R_IDLE : R_FETCH) : r_state;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      up      <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      up      <= 1'b1;
      w_state <= w_state_nx;
      r_state <= r_state_nx;
    end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_resp  <= OKAY;
    end else if (aw_hs) begin
      w_id    <= S_AXI_AWID;
      w_addr  <= S_AXI_AWADDR & ALIGN;
      w_len   <= S_AXI_AWLEN;
      w_burst <= S_AXI_AWBURST;
      w_cnt   <= S_AXI_AWLEN;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_next;
      w_cnt  <= w_cnt - 8'd1;
      w_err  <= w_err || beat_err;
      if (w_cnt == 8'd0) b_resp <= (w_err || beat_err) ? SLVERR : OKAY;
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    for (int b = 0; b < DW / 8; b++)
      if (w_hs && !w_ill && !w_oor && S_AXI_WSTRB[b]) mem[w_addr[SH +: IW]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_resp  <= OKAY;
    end else if (ar_hs) begin
      r_id    <= S_AXI_ARID;
      r_addr  <= S_AXI_ARADDR & ALIGN;
      r_len   <= S_AXI_ARLEN;
      r_burst <= S_AXI_ARBURST;
      r_cnt   <= S_AXI_ARLEN;
    end else if (r_state == R_FETCH) begin
      r_data <= (r_ill || r_oor) ? '0 : mem[r_addr[SH +: IW]];
      r_resp <= (r_ill || r_oor) ? SLVERR : OKAY;
    end else if (r_hs) begin
      r_addr <= r_next;
      r_cnt  <= r_cnt - 8'd1;
    end
  end
endmodule
